wam_round_ctrl: RTL and testbench
=================================

# wam_round_ctrl

Game-round sequencer for the whack-a-mole design. Takes the player's start/pause button and the mole logic's hit pulses, and runs the round through idle, get-ready, play, pause and game-over. It drives the enable and active-low reset of the one-minute countdown counter and watches that counter's remaining seconds. It also keeps the current score and the session high score for the display logic.

## Interface

Parameters:
- TICKS_PER_SEC, default 50_000_000: clk cycles per second in the get-ready phase (set small in simulation).
- READY_SECS, default 3: get-ready length in seconds; legal range 1..3.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-low; clears every register except the synchronizer flops.
- start_btn  in  1  raw active-high start/pause button (asynchronous to clk).
- hit  in  1  single-cycle pulse from mole logic: valid hit.
- time_left  in  6  remaining seconds from the one-minute counter (60..0).
- timer_enable  out  1  enable to the one-minute counter.
- timer_reset_n  out  1  active-low reset to the one-minute counter.
- moles_enable  out  1  permits mole spawning.
- state  out  3  IDLE=0, READY=1, PLAY=2, PAUSE=3, OVER=4.
- ready_count  out  2  get-ready seconds remaining; 0 outside READY.
- score  out  7  current score, 0..99.
- high_score  out  7  best score since reset, 0..99.
- game_over  out  1  high in OVER.

## Operation

- start_btn passes through a 2-flop synchronizer, then a rising-edge detector (third flop). The result is start_pulse, which lasts one cycle per press.
- Outputs decode only from registered state and counters. No input reaches an output combinationally.
- IDLE:
  - timer_reset_n=0, timer_enable=0, moles_enable=0.
  - start_pulse moves to READY, sets score to 0, sets ready_count to READY_SECS and clears the tick counter.
- READY:
  - timer_reset_n=1, timer_enable=0, moles_enable=0.
  - The tick counter counts 0..TICKS_PER_SEC-1 and wraps.
  - On each wrap, ready_count decrements.
  - The wrap with ready_count==1 moves to PLAY and sets ready_count to 0.
  - start_pulse and hit are ignored.
- PLAY:
  - timer_reset_n=1, timer_enable=1, moles_enable=1.
  - Priority, highest first:
    - time_left==0: go to OVER. A hit in the same cycle is not counted.
    - start_pulse: go to PAUSE. A hit in the same cycle is not counted.
    - hit: score+1, saturating at 99.
- PAUSE:
  - timer_reset_n=1, timer_enable=0, moles_enable=0.
  - hit is ignored.
  - start_pulse returns to PLAY.
- OVER:
  - timer_reset_n=1, timer_enable=0, moles_enable=0, game_over=1. The counter holds at 0.
  - score holds.
  - start_pulse goes to IDLE.
- High score: on the PLAY->OVER transition edge, high_score <= max(high_score, score). No other event changes high_score except reset.
- Undefined state encodings (5..7) go to IDLE on the next edge.

## Timing

- While reset=0: state=IDLE, score=0, high_score=0, ready_count=0, tick counter=0, game_over=0, timer_enable=0, moles_enable=0, timer_reset_n=0.
- Reset asserted mid-round forces all of the above immediately, asynchronously.
- Start press latency: start_btn sampled high at edge N gives start_pulse in the cycle after edge N+2, and state changes at edge N+3.
- A button held high produces exactly one pulse. A new pulse needs start_btn to be sampled low, then high again.
- READY lasts exactly READY_SECS*TICKS_PER_SEC cycles. ready_count steps down every TICKS_PER_SEC cycles.
- PLAY begins with timer_enable=1 in the first PLAY cycle.
- hit sampled high at edge M in PLAY makes score+1 visible after edge M.
- The transition into OVER and the high_score update happen on the same edge.

## Test plan

Bench settings: TICKS_PER_SEC=4, READY_SECS=3.

- Reset check: assert reset=0, then release → state=0, score=0, high_score=0, timer_reset_n=0, all enables 0.
- Start sequence: pulse start_btn high for 1 cycle → READY 3 edges later; ready_count shows 3, 2, 1 for 4 cycles each; PLAY after 12 cycles with timer_enable=1, moles_enable=1, timer_reset_n=1.
- Scoring: in PLAY, 5 hit pulses → score=5. Then 120 more → score=99 (saturated).
- Pause: start press in PLAY → PAUSE, timer_enable=0; 3 hits leave score unchanged. A second press → PLAY. A held button gives only one transition.
- Game over:
  - Score 7, then time_left=0 driven together with hit → OVER, game_over=1, score=7, high_score=7.
  - Press → IDLE. Next game with score 4 → high_score stays 7.
- Mid-round reset: assert reset in PLAY with score 30 → state=IDLE, score=0, high_score=0, timer_reset_n=0 before the next clk edge.

Source files
------------

// File: rtl/wam_round_ctrl_if.sv
// Signal bundle between the round sequencer and the rest of the whack-a-mole game:
// button/hit/timer inputs, and timer control, state and scores outputs.
interface wam_round_ctrl_if;
   logic       start_btn;
   logic       hit;
   logic [5:0] time_left;
   logic       timer_enable;
   logic       timer_reset_n;
   logic       moles_enable;
   logic [2:0] state;
   logic [1:0] ready_count;
   logic [6:0] score;
   logic [6:0] high_score;
   logic       game_over;

   modport master (
      output start_btn, hit, time_left,
      input  timer_enable, timer_reset_n, moles_enable, state, ready_count,
             score, high_score, game_over
   );

   modport slave (
      input  start_btn, hit, time_left,
      output timer_enable, timer_reset_n, moles_enable, state, ready_count,
             score, high_score, game_over
   );
endinterface

// File: rtl/wam_round_ctrl.sv
// Whack-a-mole round sequencer: idle -> get-ready -> play <-> pause -> game-over,
// driving the one-minute counter and tracking current and session-high score.
module wam_round_ctrl #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int READY_SECS    = 3
) (
   input logic              clk,
   input logic              reset,
   wam_round_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READY = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam int            TW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_MAX   = TW'(TICKS_PER_SEC - 1);
   localparam logic [1:0]    READY_INIT = 2'(READY_SECS);
   localparam logic [6:0]    SCORE_MAX  = 7'd99;

   state_t        st, st_nxt;
   logic [6:0]    score, score_nxt;
   logic [6:0]    high_score, high_score_nxt;
   logic [1:0]    ready_count, ready_count_nxt;
   logic [TW-1:0] tick, tick_nxt;

   // Synchronizer flops are deliberately left out of reset so the button
   // history survives a mid-round reset unchanged.
   logic [2:0] sync_q;
   logic       start_pulse;

   always_ff @(posedge clk) begin
      sync_q <= {sync_q[1:0], bus.start_btn};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) start_pulse <= 1'b0;
      else        start_pulse <= sync_q[1] & ~sync_q[2];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st          <= IDLE;
         score       <= '0;
         high_score  <= '0;
         ready_count <= '0;
         tick        <= '0;
      end else begin
         st          <= st_nxt;
         score       <= score_nxt;
         high_score  <= high_score_nxt;
         ready_count <= ready_count_nxt;
         tick        <= tick_nxt;
      end
   end

   always_comb begin
      st_nxt          = st;
      score_nxt       = score;
      high_score_nxt  = high_score;
      ready_count_nxt = ready_count;
      tick_nxt        = tick;
      case (st)
         IDLE: begin
            if (start_pulse) begin
               st_nxt          = READY;
               score_nxt       = '0;
               ready_count_nxt = READY_INIT;
               tick_nxt        = '0;
            end
         end
         READY: begin
            if (tick == TICK_MAX) begin
               tick_nxt = '0;
               if (ready_count == 2'd1) begin
                  st_nxt          = PLAY;
                  ready_count_nxt = '0;
               end else begin
                  ready_count_nxt = ready_count - 2'd1;
               end
            end else begin
               tick_nxt = tick + TW'(1);
            end
         end
         PLAY: begin
            // Timeout beats pause, and both swallow a coincident hit.
            if (bus.time_left == 6'd0) begin
               st_nxt = OVER;
               if (score > high_score) high_score_nxt = score;
            end else if (start_pulse) begin
               st_nxt = PAUSE;
            end else if (bus.hit && score < SCORE_MAX) begin
               score_nxt = score + 7'd1;
            end
         end
         PAUSE: if (start_pulse) st_nxt = PLAY;
         OVER:  if (start_pulse) st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   assign bus.state         = st;
   assign bus.score         = score;
   assign bus.high_score    = high_score;
   assign bus.ready_count   = ready_count;
   assign bus.timer_reset_n = (st == READY) || (st == PLAY) || (st == PAUSE) || (st == OVER);
   assign bus.timer_enable  = (st == PLAY);
   assign bus.moles_enable  = (st == PLAY);
   assign bus.game_over     = (st == OVER);

endmodule

// File: tb/tb_wam_round_ctrl.sv
// Randomized scoreboard bench for wam_round_ctrl: a phase-level model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_wam_round_ctrl;
   localparam int TICKS = 4;
   localparam int RSECS = 3;

   logic clk, reset;
   int   cyc = 0;
   int   total = 0, bad = 0;

   wam_round_ctrl_if bus();

   wam_round_ctrl #(.TICKS_PER_SEC(TICKS), .READY_SECS(RSECS)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      logic [2:0] st;
      logic [1:0] rc;
      logic [6:0] sc, hs;
      logic       go, te, trn, me;
   } exp_t;

   exp_t q[$];

   // phase: 0 idle, 1 ready, 2 play, 3 pause, 4 over
   int         m_phase, m_score, m_hs, m_rcyc;
   logic [3:0] hist;

   task automatic model_reset();
      m_phase = 0; m_score = 0; m_hs = 0; m_rcyc = 0; hist = '0;
   endtask

   task automatic model_edge(input bit b, input bit h, input int tl);
      exp_t e;
      bit   pulse;
      pulse = hist[2] && !hist[3];
      case (m_phase)
         0: if (pulse) begin m_phase = 1; m_score = 0; m_rcyc = 0; end
         1: begin m_rcyc++; if (m_rcyc == RSECS * TICKS) m_phase = 2; end
         2: begin
            if (tl == 0) begin
               if (m_score > m_hs) m_hs = m_score;
               m_phase = 4;
            end else if (pulse) m_phase = 3;
            else if (h && m_score < 99) m_score++;
         end
         3: if (pulse) m_phase = 2;
         4: if (pulse) m_phase = 0;
         default: m_phase = 0;
      endcase
      hist = {hist[2:0], b};
      e.due = cyc + 1;
      e.st  = 3'(m_phase);
      e.rc  = (m_phase == 1) ? 2'(RSECS - m_rcyc / TICKS) : 2'd0;
      e.sc  = 7'(m_score);
      e.hs  = 7'(m_hs);
      e.go  = (m_phase == 4);
      e.te  = (m_phase == 2);
      e.me  = (m_phase == 2);
      e.trn = (m_phase != 0);
      q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            total++;
            if (bus.state !== e.st || bus.ready_count !== e.rc || bus.score !== e.sc ||
                bus.high_score !== e.hs || bus.game_over !== e.go || bus.timer_enable !== e.te ||
                bus.timer_reset_n !== e.trn || bus.moles_enable !== e.me) begin
               bad++;
               $display("FAIL cyc%0d: got st=%0d rc=%0d sc=%0d hs=%0d go=%b te=%b trn=%b me=%b want st=%0d rc=%0d sc=%0d hs=%0d go=%b te=%b trn=%b me=%b",
                        cyc, bus.state, bus.ready_count, bus.score, bus.high_score, bus.game_over,
                        bus.timer_enable, bus.timer_reset_n, bus.moles_enable,
                        e.st, e.rc, e.sc, e.hs, e.go, e.te, e.trn, e.me);
            end
         end
      end
   end

   task automatic step(input bit b, input bit h, input int tl);
      @(posedge clk);
      #1;
      bus.start_btn = b;
      bus.hit       = h;
      bus.time_left = 6'(tl);
      model_edge(b, h, tl);
   endtask

   task automatic idle(input int n, input bit rnd_hit);
      for (int i = 0; i < n; i++)
         step(1'b0, rnd_hit ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(1, 60));
   endtask

   task automatic press();
      step(1'b1, 1'b0, $urandom_range(1, 60));
      idle(3, 1'b0);
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(0, 2), 1'b0);
         step(1'b0, 1'b1, $urandom_range(1, 60));
      end
   endtask

   task automatic end_game();
      step(1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, bus.state, 0);
      check({tag, "_score"}, bus.score, 0);
      check({tag, "_high"},  bus.high_score, 0);
      check({tag, "_rc"},    bus.ready_count, 0);
      check({tag, "_trn"},   bus.timer_reset_n, 0);
      check({tag, "_te"},    bus.timer_enable, 0);
      check({tag, "_me"},    bus.moles_enable, 0);
      check({tag, "_go"},    bus.game_over, 0);
   endtask

   initial begin
      reset = 0;
      bus.start_btn = 0; bus.hit = 0; bus.time_left = 6'd60;
      model_reset();
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1;
      #1;
      check_reset_outputs("rst");

      // game 1: start, score 5, pause with ignored hits, held button, score 7, timeout
      press();
      idle(12, 1'b1);
      hits(5);
      press();
      hits(3);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom_range(1, 60));
      idle(4, 1'b0);
      hits(2);
      end_game();
      press();
      idle(2, 1'b1);

      // game 2: lower score keeps high score
      press();
      idle(12, 1'b1);
      hits(4);
      end_game();
      press();

      // game 3: saturation at 99
      press();
      idle(12, 1'b1);
      hits(125);
      end_game();
      press();

      // game 4: asynchronous reset mid-round
      press();
      idle(12, 1'b0);
      hits(30);
      idle(4, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      reset = 0;
      #1;
      check_reset_outputs("midrst");
      q.delete();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1;

      // restart after reset
      idle(2, 1'b1);
      press();
      idle(14, 1'b1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
